// File: rtl/alu_control_mdu.sv
// Registered EX-stage ALU control decoder with optional RV32M decode and a
// counter-driven stall sequencer for multi-cycle multiply/divide operations.
module alu_control_mdu #(
  parameter int OP_WIDTH = 5,
  parameter int M_EN     = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          ALU_Op_i,
  input  logic [2:0]          funct3_i,
  output logic [OP_WIDTH-1:0] ALU_Operation_o,
  output logic                op_valid_o,
  output logic                illegal_o,
  output logic                stall_o,
  output logic                mdu_start_o,
  output logic                mdu_done_o
);

  localparam logic [5:0]          MUL_CNT    = 6'(MUL_LAT - 1);
  localparam logic [5:0]          DIV_CNT    = 6'(DIV_LAT - 1);
  localparam logic [OP_WIDTH-1:0] OP_ILLEGAL = '1;

  typedef enum logic {IDLE, BUSY} state_t;

  // Returns {illegal, code[4:0]}; M ops are the only codes with bit 4 set.
  function automatic logic [5:0] decode_op(input logic [6:0] f7,
                                           input logic [2:0] aop,
                                           input logic [2:0] f3);
    logic [5:0] r;
    r = 6'h20;
    case (aop)
      3'b000: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  r = 6'd0;
            3'b001:  r = 6'd4;
            3'b100:  r = 6'd7;
            3'b101:  r = 6'd5;
            3'b110:  r = 6'd3;
            3'b111:  r = 6'd6;
            default: r = 6'h20;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          r = 6'd1;
        end else if (f7 == 7'b0000001 && M_EN != 0) begin
          r = {3'b010, f3};
        end
      end
      3'b001: begin
        case (f3)
          3'b000:  r = 6'd0;
          3'b100:  r = 6'd7;
          3'b110:  r = 6'd3;
          3'b111:  r = 6'd6;
          3'b001:  r = (f7 == 7'b0000000) ? 6'd4 : 6'h20;
          3'b101:  r = (f7 == 7'b0000000) ? 6'd5 : 6'h20;
          default: r = 6'h20;
        endcase
      end
      3'b010: r = 6'd2;
      3'b110: r = 6'd13;
      3'b011: begin
        case (f3)
          3'b000:  r = 6'd8;
          3'b001:  r = 6'd9;
          3'b100:  r = 6'd10;
          default: r = 6'h20;
        endcase
      end
      3'b100:  r = (f3 == 3'b010) ? 6'd11 : 6'h20;
      3'b101:  r = (f3 == 3'b010) ? 6'd12 : 6'h20;
      3'b111:  r = (f3 == 3'b000) ? 6'd14 : 6'h20;
      default: r = 6'h20;
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   alu_op_p1, alu_op_d;
  logic                  vld_p1, vld_d;
  logic                  ill_p1, ill_d;
  logic                  start_p1, start_d;
  logic                  done_p1, done_d;

  logic [5:0]            dec;
  logic [OP_WIDTH-1:0]   dec_code;
  logic                  dec_ill;
  logic                  is_m;
  logic [5:0]            lat_cnt;

  // Decode stage: combinational from the ID/EX inputs
  always_comb begin
    dec      = decode_op(funct7_i, ALU_Op_i, funct3_i);
    dec_ill  = dec[5];
    dec_code = dec_ill ? OP_ILLEGAL : OP_WIDTH'(dec[4:0]);
    is_m     = !dec_ill && dec[4];
    lat_cnt  = funct3_i[2] ? DIV_CNT : MUL_CNT;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_op_d = alu_op_p1;
    vld_d    = vld_p1;
    ill_d    = ill_p1;
    start_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          alu_op_d = dec_code;
          vld_d    = 1'b1;
          ill_d    = dec_ill;
          start_d  = is_m;
          if (is_m && lat_cnt != 6'd0) begin
            cnt_d   = lat_cnt;
            state_d = BUSY;
          end
        end else begin
          alu_op_d = '0;
          vld_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // EX stage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      alu_op_p1 <= '0;
      vld_p1    <= 1'b0;
      ill_p1    <= 1'b0;
      start_p1  <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_op_p1 <= alu_op_d;
      vld_p1    <= vld_d;
      ill_p1    <= ill_d;
      start_p1  <= start_d;
      done_p1   <= done_d;
    end
  end

  assign ALU_Operation_o = alu_op_p1;
  assign op_valid_o      = vld_p1;
  assign illegal_o       = ill_p1;
  assign stall_o         = (state_q == BUSY);
  assign mdu_start_o     = start_p1;
  assign mdu_done_o      = done_p1;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Testbench for alu_control_mdu: default, M_EN=0 and MUL_LAT=1 instances share
// one stimulus stream; per-cycle expectations for the default instance are queued.
module tb_alu_control_mdu;

  logic       clk, reset, valid_i, flush_i;
  logic [6:0] funct7_i;
  logic [2:0] ALU_Op_i, funct3_i;

  logic [4:0] op0, op1, op2;
  logic       ov0, il0, st0, ms0, md0;
  logic       ov1, il1, st1, ms1, md1;
  logic       ov2, il2, st2, ms2, md2;

  alu_control_mdu #(.OP_WIDTH(5), .M_EN(1), .MUL_LAT(2), .DIV_LAT(8)) dut0 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i),
    .ALU_Operation_o(op0), .op_valid_o(ov0), .illegal_o(il0), .stall_o(st0),
    .mdu_start_o(ms0), .mdu_done_o(md0));

  alu_control_mdu #(.OP_WIDTH(5), .M_EN(0), .MUL_LAT(2), .DIV_LAT(8)) dut1 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i),
    .ALU_Operation_o(op1), .op_valid_o(ov1), .illegal_o(il1), .stall_o(st1),
    .mdu_start_o(ms1), .mdu_done_o(md1));

  alu_control_mdu #(.OP_WIDTH(5), .M_EN(1), .MUL_LAT(1), .DIV_LAT(8)) dut2 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i), .funct3_i(funct3_i),
    .ALU_Operation_o(op2), .op_valid_o(ov2), .illegal_o(il2), .stall_o(st2),
    .mdu_start_o(ms2), .mdu_done_o(md2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] f7;
    logic [2:0] aop;
    logic [2:0] f3;
    logic [4:0] code;
    logic       ill;
  } vec_t;

  typedef struct {
    string      nm;
    logic [4:0] op;
    logic       ov, il, st, ms, md;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] f7, input logic [2:0] aop, input logic [2:0] f3,
                     input logic [4:0] code, input logic ill);
    vec_t v;
    v.f7 = f7; v.aop = aop; v.f3 = f3; v.code = code; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic v, input logic f, input logic [6:0] f7,
                       input logic [2:0] aop, input logic [2:0] f3);
    valid_i = v; flush_i = f; funct7_i = f7; ALU_Op_i = aop; funct3_i = f3;
  endtask

  task automatic expect0(input string nm, input logic [4:0] op, input logic ov,
                         input logic il, input logic st, input logic ms, input logic md);
    exp_t e;
    e.nm = nm; e.op = op; e.ov = ov; e.il = il; e.st = st; e.ms = ms; e.md = md;
    sbq.push_back(e);
  endtask

  task automatic check0(input exp_t e);
    chk({e.nm, "_op"},    op0, e.op);
    chk({e.nm, "_vld"},   ov0, e.ov);
    chk({e.nm, "_ill"},   il0, e.il);
    chk({e.nm, "_stall"}, st0, e.st);
    chk({e.nm, "_start"}, ms0, e.ms);
    chk({e.nm, "_done"},  md0, e.md);
  endtask

  // Advance one cycle and compare dut0 against the oldest queued expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      check0(e);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 3'd0, 3'd0);
    #2;
    chk("rst_async_op", op0, 0);
    chk("rst_async_stall", st0, 0);
    chk("rst_async_vld", ov0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      expect0("idle_after_rst", 5'd0, 0, 0, 0, 0, 0);
      tick();
    end

    add(7'h00, 3'd0, 3'd0, 5'd0,  0); add(7'h00, 3'd0, 3'd1, 5'd4,  0);
    add(7'h00, 3'd0, 3'd4, 5'd7,  0); add(7'h00, 3'd0, 3'd5, 5'd5,  0);
    add(7'h00, 3'd0, 3'd6, 5'd3,  0); add(7'h00, 3'd0, 3'd7, 5'd6,  0);
    add(7'h20, 3'd0, 3'd0, 5'd1,  0); add(7'h00, 3'd0, 3'd2, 5'd31, 1);
    add(7'h20, 3'd0, 3'd5, 5'd31, 1); add(7'h55, 3'd1, 3'd0, 5'd0,  0);
    add(7'h20, 3'd1, 3'd4, 5'd7,  0); add(7'h7f, 3'd1, 3'd6, 5'd3,  0);
    add(7'h01, 3'd1, 3'd7, 5'd6,  0); add(7'h00, 3'd1, 3'd1, 5'd4,  0);
    add(7'h00, 3'd1, 3'd5, 5'd5,  0); add(7'h20, 3'd1, 3'd5, 5'd31, 1);
    add(7'h00, 3'd1, 3'd2, 5'd31, 1); add(7'h33, 3'd2, 3'd5, 5'd2,  0);
    add(7'h7f, 3'd6, 3'd3, 5'd13, 0); add(7'h00, 3'd3, 3'd0, 5'd8,  0);
    add(7'h00, 3'd3, 3'd1, 5'd9,  0); add(7'h00, 3'd3, 3'd4, 5'd10, 0);
    add(7'h00, 3'd3, 3'd5, 5'd31, 1); add(7'h00, 3'd4, 3'd2, 5'd11, 0);
    add(7'h00, 3'd4, 3'd0, 5'd31, 1); add(7'h00, 3'd5, 3'd2, 5'd12, 0);
    add(7'h00, 3'd7, 3'd0, 5'd14, 0); add(7'h00, 3'd7, 3'd2, 5'd31, 1);

    foreach (tbl[i]) begin
      drive(1'b1, 1'b0, tbl[i].f7, tbl[i].aop, tbl[i].f3);
      expect0($sformatf("dec%0d", i), tbl[i].code, 1, tbl[i].ill, 0, 0, 0);
      tick();
      chk($sformatf("dec%0d_men0_op", i), op1, tbl[i].code);
      chk($sformatf("dec%0d_men0_ill", i), il1, tbl[i].ill);
    end

    // flushed LW becomes a bubble
    drive(1'b1, 1'b1, 7'h00, 3'd5, 3'd2);
    expect0("flush_lw", 5'd0, 0, 0, 0, 0, 0);
    tick();

    // MUL across all three instances
    drive(1'b1, 1'b0, 7'h01, 3'd0, 3'd0);
    expect0("mul_c1", 5'd16, 1, 0, 1, 1, 0);
    tick();
    chk("men0_mul_op", op1, 31);
    chk("men0_mul_ill", il1, 1);
    chk("men0_mul_stall", st1, 0);
    chk("lat1_mul_op", op2, 16);
    chk("lat1_mul_start", ms2, 1);
    chk("lat1_mul_stall", st2, 0);
    drive(1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
    expect0("mul_c2", 5'd16, 1, 0, 0, 0, 1);
    tick();
    chk("lat1_mul_done", md2, 0);
    chk("lat1_mul_op_c2", op2, 0);
    chk("men0_mul_stall_c2", st1, 0);
    expect0("mul_c3", 5'd0, 0, 0, 0, 0, 0);
    tick();

    // MUL then ADD back-to-back
    drive(1'b1, 1'b0, 7'h01, 3'd0, 3'd0);
    expect0("b2b_c1", 5'd16, 1, 0, 1, 1, 0);
    tick();
    drive(1'b1, 1'b0, 7'h00, 3'd0, 3'd0);
    expect0("b2b_c2", 5'd16, 1, 0, 0, 0, 1);
    tick();
    expect0("b2b_c3", 5'd0, 1, 0, 0, 0, 0);
    tick();

    // DIV with junk on valid/flush/decode while BUSY
    drive(1'b1, 1'b0, 7'h01, 3'd0, 3'd4);
    expect0("div_c1", 5'd20, 1, 0, 1, 1, 0);
    tick();
    for (int k = 2; k <= 8; k++) begin
      drive(k[0], k[1], 7'h00, 3'd3, 3'(k));
      expect0($sformatf("div_c%0d", k), 5'd20, 1, 0, (k < 8), 0, (k == 8));
      tick();
    end
    drive(1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
    expect0("div_after", 5'd0, 0, 0, 0, 0, 0);
    tick();

    // reset in the middle of a DIV
    drive(1'b1, 1'b0, 7'h01, 3'd0, 3'd5);
    expect0("rdiv_c1", 5'd21, 1, 0, 1, 1, 0);
    tick();
    drive(1'b0, 1'b0, 7'h00, 3'd0, 3'd0);
    expect0("rdiv_c2", 5'd21, 1, 0, 1, 0, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy_stall", st0, 0);
    chk("rst_busy_op", op0, 0);
    chk("rst_busy_vld", ov0, 0);
    chk("rst_busy_start", ms0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect0("after_rst", 5'd0, 0, 0, 0, 0, 0);
      tick();
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
